// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (scalar and
// multi-beat vector accesses) and the GPU pixel fetcher, with anti-starvation.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_vec,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [63:0]       cpu_wdata_v,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic [127:0]      cpu_rdata_v,
  input  logic              gpu_req,
  input  logic              gpu_urgent,
  input  logic [31:0]       gpu_addr,
  output logic              gpu_grant,
  output logic              gpu_rvalid,
  output logic [31:0]       gpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_ISSUE = 2'd1,
    CPU_WAIT  = 2'd2,
    CPU_DONE  = 2'd3
  } state_t;

  // Tracks who owns the read data returning on the next cycle.
  typedef struct packed {
    logic       valid;
    logic       owner_cpu;
    logic       vec;
    logic [1:0] beat;
  } rd_tag_t;

  state_t           state, state_nxt;
  logic [1:0]       beat_cnt, beat_cnt_nxt;
  logic [CNT_W-1:0] starve_cnt;
  rd_tag_t          tag;

  logic       arb_en;
  logic       cpu_contend;
  logic       gpu_win;
  logic       cpu_win;
  logic       cpu_beat_en;
  logic [1:0] cur_beat;
  logic [1:0] last_beat;
  logic       is_last;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              gpu_addr[31:ADDR_W+2], gpu_addr[1:0]};

  // In CPU_WAIT the port is free and the CPU cannot be granted, so the GPU
  // only has to compete with a CPU request in IDLE and CPU_DONE.
  assign arb_en      = (state != CPU_ISSUE);
  assign cpu_contend = cpu_req && (state != CPU_WAIT);
  assign gpu_win     = !rst && arb_en && gpu_req &&
                       (gpu_urgent || !cpu_contend ||
                        (starve_cnt == CNT_W'(STARVE_MAX)));
  assign cpu_win     = !rst && (state == IDLE) && cpu_req && !gpu_win;
  assign cpu_beat_en = cpu_win || (!rst && (state == CPU_ISSUE));
  assign cur_beat    = (state == CPU_ISSUE) ? beat_cnt : 2'd0;
  assign last_beat   = !cpu_vec ? 2'd0 : (cpu_we ? 2'd1 : 2'd3);
  assign is_last     = (cur_beat == last_beat);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (cpu_win) begin
          if (is_last) begin
            state_nxt = cpu_we ? CPU_DONE : CPU_WAIT;
          end else begin
            state_nxt    = CPU_ISSUE;
            beat_cnt_nxt = 2'd1;
          end
        end
      end
      CPU_ISSUE: begin
        if (is_last) begin
          state_nxt    = cpu_we ? CPU_DONE : CPU_WAIT;
          beat_cnt_nxt = 2'd0;
        end else begin
          beat_cnt_nxt = 2'(beat_cnt + 2'd1);
        end
      end
      CPU_WAIT: state_nxt = CPU_DONE;
      CPU_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Memory port drive
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    gpu_grant = 1'b0;
    if (gpu_win) begin
      mem_en    = 1'b1;
      mem_addr  = gpu_addr[ADDR_W+1:2];
      gpu_grant = 1'b1;
    end else if (cpu_beat_en) begin
      mem_en   = 1'b1;
      mem_we   = cpu_we;
      mem_addr = cpu_addr[ADDR_W+1:2] + ADDR_W'(cur_beat);
      if (cpu_we) begin
        if (cpu_vec) begin
          mem_wdata = cur_beat[0] ? cpu_wdata_v[63:32] : cpu_wdata_v[31:0];
        end else begin
          mem_wdata = cpu_wdata;
        end
      end
    end
  end

  assign cpu_done   = (state == CPU_DONE);
  assign cpu_stall  = !rst && cpu_req && !cpu_done;
  assign gpu_rvalid = tag.valid && !tag.owner_cpu;
  assign gpu_rdata  = gpu_rvalid ? mem_rdata : 32'd0;

  // Starvation counter, read tag and CPU read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      tag         <= '0;
      cpu_rdata   <= '0;
      cpu_rdata_v <= '0;
    end else begin
      if (gpu_win) begin
        starve_cnt <= '0;
      end else if (cpu_win && gpu_req && (starve_cnt < CNT_W'(STARVE_MAX))) begin
        starve_cnt <= CNT_W'(starve_cnt + CNT_W'(1));
      end

      tag.valid     <= mem_en && !mem_we;
      tag.owner_cpu <= cpu_beat_en;
      tag.vec       <= cpu_vec;
      tag.beat      <= cur_beat;

      if (tag.valid && tag.owner_cpu) begin
        if (tag.vec) begin
          cpu_rdata_v[{tag.beat, 5'd0} +: 32] <= mem_rdata;
        end else begin
          cpu_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: behavioural memory, issue log and
// hand-computed expectations for latency, beat sequencing and arbitration.
module tb_dmem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic         cpu_vec = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [63:0]  cpu_wdata_v = '0;
  logic         cpu_stall;
  logic         cpu_done;
  logic [31:0]  cpu_rdata;
  logic [127:0] cpu_rdata_v;
  logic         gpu_req = 1'b0;
  logic         gpu_urgent = 1'b0;
  logic [31:0]  gpu_addr = '0;
  logic         gpu_grant;
  logic         gpu_rvalid;
  logic [31:0]  gpu_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [17:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;

  dmem_port_arbiter #(.ADDR_W(18), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vec(cpu_vec), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wdata_v(cpu_wdata_v), .cpu_stall(cpu_stall),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_rdata_v(cpu_rdata_v),
    .gpu_req(gpu_req), .gpu_urgent(gpu_urgent), .gpu_addr(gpu_addr),
    .gpu_grant(gpu_grant), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<18)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          cyc;
    logic        gnt;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wd;
  } ent_t;
  ent_t log_q[$];

  always @(negedge clk) begin
    if (mem_en) log_q.push_back('{cyc_n, gpu_grant, mem_we, mem_addr, mem_wdata});
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          t0, lat, stalls;
  logic        stall_at_done, rv_at_done;
  logic [31:0] rd_at_done;

  // Issue one CPU access from posedge+1 and follow it to cpu_done.
  task automatic run_cpu(input logic we, input logic vec, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [63:0] wdv, input logic keep);
    cpu_req = 1'b1; cpu_we = we; cpu_vec = vec; cpu_addr = addr;
    cpu_wdata = wd; cpu_wdata_v = wdv;
    log_q.delete();
    t0 = cyc_n; lat = 0; stalls = 0;
    #3;
    while (!cpu_done && lat < 20) begin
      if (cpu_stall) stalls++;
      @(posedge clk);
      #4;
      lat++;
    end
    chk("done_seen", 128'(cpu_done), 128'd1);
    stall_at_done = cpu_stall;
    rv_at_done    = gpu_rvalid;
    rd_at_done    = gpu_rdata;
    @(posedge clk);
    #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  int gcnt;

  initial begin
    mem[16]  = 32'hDEADBEEF;
    mem[128] = 32'hA0A0A0A1;
    mem[129] = 32'hB0B0B0B2;
    mem[130] = 32'hC0C0C0C3;
    mem[131] = 32'hD0D0D0D4;
    mem[200] = 32'h0BADF00D;

    // Reset holds every output low even with both requesters active
    step();
    cpu_req = 1'b1; gpu_req = 1'b1; cpu_addr = 32'h40; gpu_addr = 32'h40;
    #3;
    chk("rst_mem_en", 128'(mem_en), 128'd0);
    chk("rst_gpu_grant", 128'(gpu_grant), 128'd0);
    chk("rst_stall", 128'(cpu_stall), 128'd0);
    chk("rst_done", 128'(cpu_done), 128'd0);
    chk("rst_rdata", 128'(cpu_rdata), 128'd0);
    step();
    cpu_req = 1'b0; gpu_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    #3;
    chk("idle_mem_en", 128'(mem_en), 128'd0);
    chk("idle_mem_we", 128'(mem_we), 128'd0);
    step();

    // Scalar read of word 16
    run_cpu(1'b0, 1'b0, 32'h40, 32'h0, 64'h0, 1'b0);
    chk("sr_lat", 128'(lat), 128'd2);
    chk("sr_stalls", 128'(stalls), 128'd2);
    chk("sr_stall_done", 128'(stall_at_done), 128'd0);
    chk("sr_rdata", 128'(cpu_rdata), 128'hDEADBEEF);
    chk("sr_nissue", 128'(log_q.size()), 128'd1);
    if (log_q.size() >= 1) begin
      chk("sr_addr", 128'(log_q[0].addr), 128'd16);
      chk("sr_cyc", 128'(log_q[0].cyc - t0), 128'd0);
    end

    // Vector write, two beats
    run_cpu(1'b1, 1'b1, 32'h100, 32'h0, 64'h11223344_55667788, 1'b0);
    chk("vw_lat", 128'(lat), 128'd2);
    chk("vw_nissue", 128'(log_q.size()), 128'd2);
    if (log_q.size() >= 2) begin
      chk("vw_b0_addr", 128'(log_q[0].addr), 128'd64);
      chk("vw_b0_data", 128'(log_q[0].wd), 128'h55667788);
      chk("vw_b1_addr", 128'(log_q[1].addr), 128'd65);
      chk("vw_b1_data", 128'(log_q[1].wd), 128'h11223344);
      chk("vw_b1_we", 128'(log_q[1].we), 128'd1);
    end
    chk("vw_mem64", 128'(mem[64]), 128'h55667788);
    chk("vw_mem65", 128'(mem[65]), 128'h11223344);

    // Vector read, four beats
    run_cpu(1'b0, 1'b1, 32'h200, 32'h0, 64'h0, 1'b0);
    chk("vr_lat", 128'(lat), 128'd5);
    chk("vr_nissue", 128'(log_q.size()), 128'd4);
    if (log_q.size() >= 4) chk("vr_b3_addr", 128'(log_q[3].addr), 128'd131);
    chk("vr_rdata_v", cpu_rdata_v, 128'hD0D0D0D4_C0C0C0C3_B0B0B0B2_A0A0A0A1);
    chk("vr_rdata_hold", 128'(cpu_rdata), 128'hDEADBEEF);

    // Vector read with GPU pending: GPU slots in during CPU_WAIT
    mem[128] = 32'h12340001;
    gpu_req = 1'b1; gpu_addr = 32'h40;
    run_cpu(1'b0, 1'b1, 32'h200, 32'h0, 64'h0, 1'b0);
    gpu_req = 1'b0;
    chk("vg_lat", 128'(lat), 128'd5);
    chk("vg_nissue", 128'(log_q.size()), 128'd5);
    gcnt = 0;
    for (int i = 0; i < log_q.size() && i < 4; i++) if (log_q[i].gnt) gcnt++;
    chk("vg_no_preempt", 128'(gcnt), 128'd0);
    if (log_q.size() >= 5) begin
      chk("vg_gnt", 128'(log_q[4].gnt), 128'd1);
      chk("vg_gnt_cyc", 128'(log_q[4].cyc - t0), 128'd4);
      chk("vg_gnt_addr", 128'(log_q[4].addr), 128'd16);
    end
    chk("vg_rvalid", 128'(rv_at_done), 128'd1);
    chk("vg_rdata", 128'(rd_at_done), 128'hDEADBEEF);
    chk("vg_rdata_v", cpu_rdata_v, 128'hD0D0D0D4_C0C0C0C3_B0B0B0B2_12340001);

    // Continuous CPU writes vs non-urgent GPU: GPU gets in after 8 CPU grants
    gpu_req = 1'b1; gpu_addr = 32'h40;
    for (int i = 0; i < 9; i++) begin
      run_cpu(1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'h5000 + 32'(i), 64'h0, (i != 8));
      gcnt = 0;
      foreach (log_q[j]) if (log_q[j].gnt) gcnt++;
      chk($sformatf("starve_gnt%0d", i), 128'(gcnt), (i == 7) ? 128'd1 : 128'd0);
    end
    gpu_req = 1'b0;
    chk("starve_mem", 128'(mem[256 + 8]), 128'h5008);

    // Urgent GPU beats a simultaneous CPU request
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vec = 1'b0; cpu_addr = 32'h300; cpu_wdata = 32'hCAFE0001;
    gpu_req = 1'b1; gpu_urgent = 1'b1; gpu_addr = 32'h40;
    #3;
    chk("urg_grant", 128'(gpu_grant), 128'd1);
    chk("urg_addr", 128'(mem_addr), 128'd16);
    chk("urg_we", 128'(mem_we), 128'd0);
    step();
    gpu_req = 1'b0; gpu_urgent = 1'b0;
    #3;
    chk("urg_rvalid", 128'(gpu_rvalid), 128'd1);
    chk("urg_rdata", 128'(gpu_rdata), 128'hDEADBEEF);
    chk("urg_cpu_we", 128'(mem_we), 128'd1);
    chk("urg_cpu_addr", 128'(mem_addr), 128'd192);
    step();
    #3;
    chk("urg_done", 128'(cpu_done), 128'd1);
    step();
    cpu_req = 1'b0;
    chk("urg_mem", 128'(mem[192]), 128'hCAFE0001);

    // Reset during beat 2 of a vector read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vec = 1'b1; cpu_addr = 32'h200;
    step();
    step();
    rst = 1'b1;
    #3;
    chk("rmb_mem_en", 128'(mem_en), 128'd0);
    chk("rmb_done", 128'(cpu_done), 128'd0);
    chk("rmb_rvalid", 128'(gpu_rvalid), 128'd0);
    chk("rmb_rdata_v", cpu_rdata_v, 128'd0);
    step();
    #3;
    chk("rmb_done2", 128'(cpu_done), 128'd0);
    cpu_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    #3;
    chk("rmb_idle", 128'(mem_en), 128'd0);
    chk("rmb_stall", 128'(cpu_stall), 128'd0);
    step();
    run_cpu(1'b0, 1'b0, 32'h320, 32'h0, 64'h0, 1'b0);
    chk("post_lat", 128'(lat), 128'd2);
    chk("post_rdata", 128'(cpu_rdata), 128'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and shares the single-port 32-bit data memory between two requesters: the CPU MEM stage and the display (GPU) pixel fetcher.
- CPU scalar accesses take one memory beat.
- CPU vector accesses are split into multiple beats: 64-bit packed vector store = 2 beats, 128-bit vector load = 4 beats.
- Generates the CPU stall that freezes the pipeline until the access completes.
- GPU single-word reads are interleaved under a priority and anti-starvation policy.

Parameters:
ADDR_W, 18, memory word-address width
STARVE_MAX, 8, max consecutive CPU grants while gpu_req is pending before the GPU is forced in

Ports:
clk  in  1  system clock
rst  in  1  reset
cpu_req  in  1  CPU access request; held stable until cpu_done
cpu_we  in  1  1=write, 0=read
cpu_vec  in  1  vector access
cpu_addr  in  32  byte address; bits [1:0] ignored
cpu_wdata  in  32  scalar write data
cpu_wdata_v  in  64  packed vector write data
cpu_stall  out  1  pipeline stall
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  32  scalar read result
cpu_rdata_v  out  128  vector read result
gpu_req  in  1  GPU read request
gpu_urgent  in  1  GPU line buffer low; raises GPU priority
gpu_addr  in  32  byte address; bits [1:0] ignored
gpu_grant  out  1  GPU request issued this cycle
gpu_rvalid  out  1  gpu_rdata valid
gpu_rdata  out  32  GPU read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid the cycle after a read issue

Behaviour:
- Clock and reset: clock is clk; reset is rst, asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; beat counter 0; starve_cnt 0; read-tag register cleared; cpu_rdata and cpu_rdata_v cleared.
- FSM states: IDLE, CPU_ISSUE, CPU_WAIT, CPU_DONE.
- Beat count N:
  - scalar: N=1
  - vector write: N=2
  - vector read: N=4
- Arbitration runs in IDLE, CPU_WAIT and CPU_DONE, i.e. whenever no CPU beats remain to issue.
- GPU grant condition: gpu_req AND (gpu_urgent OR !cpu_req OR starve_cnt==STARVE_MAX).
- CPU grant condition: cpu_req AND the GPU is not granted. CPU grants happen only from IDLE; the CPU is never re-granted in CPU_WAIT or CPU_DONE.
- GPU grant is a single cycle:
  - mem_en=1, mem_we=0, mem_addr=gpu_addr[ADDR_W+1:2], gpu_grant=1.
  - Back-to-back GPU grants are allowed.
- CPU grant: IDLE→CPU_ISSUE, with the first beat issued in that same cycle.
- CPU_ISSUE, beat k in 0..N-1:
  - mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr[ADDR_W+1:2]+k (wraps modulo 2^ADDR_W).
  - mem_wdata: scalar = cpu_wdata; vector beat k = cpu_wdata_v[32k+31:32k].
  - Beats issue on consecutive cycles.
  - After beat N-1: reads go to CPU_WAIT, writes go to CPU_DONE.
- CPU_WAIT lasts 1 cycle, then goes to CPU_DONE.
- CPU_DONE: cpu_done=1 for one cycle, then IDLE.
- Read tag: every read issue registers {valid, owner, beat}.
  - Owner GPU, next cycle: gpu_rvalid=1 and gpu_rdata=mem_rdata (combinational).
  - Owner CPU, next-cycle edge: mem_rdata is captured into cpu_rdata (scalar) or cpu_rdata_v[32k+31:32k] (vector).
  - CPU results hold until the next CPU read capture.
- Latency from grant cycle T:
  - scalar write: done at T+1
  - vector write: done at T+2
  - scalar read: done at T+2
  - vector read: done at T+5
- cpu_stall = cpu_req AND !cpu_done (combinational).
- starve_cnt:
  - increments (saturating at STARVE_MAX) on each CPU grant made while gpu_req=1
  - clears on a GPU grant
- Simultaneous requests with gpu_urgent=0 and starve_cnt<STARVE_MAX: the CPU wins.
- No preemption: the GPU never interrupts CPU_ISSUE beats.
- Reset mid-burst: remaining beats are abandoned, cpu_done does not pulse, no gpu_rvalid is produced for in-flight reads.
- When idle (no grant): mem_en=0 and mem_we=0.

Test Plan:
- Scalar read, cpu_addr=0x40, memory word 16=0xDEADBEEF → mem_en at T with mem_addr=16; cpu_done at T+2; cpu_rdata=0xDEADBEEF; cpu_stall high T..T+1.
- Vector write, cpu_addr=0x100, cpu_wdata_v=0x11223344_55667788 → beats at T/T+1: addr 64 data 0x55667788, addr 65 data 0x11223344; done at T+2.
- Vector read from addr 0x200, words 128..131=A,B,C,D → four consecutive issues; cpu_rdata_v={D,C,B,A}; done at T+5.
- Vector read with gpu_req=1 throughout → no GPU grant during the 4 beats; GPU granted in CPU_WAIT; gpu_rvalid in CPU_DONE; CPU data not corrupted.
- Both requesting continuously with STARVE_MAX=8, gpu_urgent=0 → GPU granted after exactly 8 CPU grants; with gpu_urgent=1 the GPU wins immediately.
- rst asserted during beat 2 of a vector read → mem_en drops immediately; no cpu_done, no gpu_rvalid; after release, FSM is IDLE and a new scalar read completes normally.
